// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexes eight hex digits onto one shared 7-segment decoder.
//   A prescaler gives each digit TICK_DIV clocks of dwell. A new value is
//   captured into a shadow register on load. It moves to the displayed
//   (active) register only when the scan wraps from digit 7 to digit 0, so
//   a single frame never mixes digits from two values.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   value_in    eight nibbles, digit i = value_in[4i+3:4i]
//   load        one-cycle strobe capturing value_in
//   blank_lz    enables leading-zero blanking (digit 0 always lit)
//   number      registered nibble for the 7-segment decoder
//   digit_sel   registered active-low anode enables, one-cold or all ones
//   pending     a captured value is waiting for the next frame boundary
//   frame_done  one-cycle pulse after each 7->0 scan wrap
module hex_display_scanner #(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  number,
  output logic [7:0]  digit_sel,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   active_q, active_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    number_q, number_d;
  logic [7:0]    digit_sel_q, digit_sel_d;

  logic          tick;
  logic          wrap;
  logic          blank;
  logic [31:0]   upper;

  assign tick = (count_q == CNT_LAST);
  assign wrap = tick && (idx_q == 3'd7);

  // Nibbles idx..7 shifted down to the bottom; all zero means this digit is
  // a leading zero.
  assign upper = active_q >> {idx_q, 2'b00};
  assign blank = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);

  always_comb begin
    count_d      = tick ? '0 : count_q + CW'(1);
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    frame_done_d = wrap;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;

    if (load) begin
      // A load on the wrap cycle goes straight to the display; otherwise it
      // waits in the shadow (last load wins).
      shadow_d = value_in;
      if (wrap) begin
        active_d  = value_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    number_d    = blank ? 4'h0  : upper[3:0];
    digit_sel_d = blank ? 8'hFF : ~(8'h01 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      idx_q        <= 3'd0;
      shadow_q     <= 32'd0;
      active_q     <= 32'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      number_q     <= 4'h0;
      digit_sel_q  <= 8'hFF;
    end else begin
      count_q      <= count_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      number_q     <= number_d;
      digit_sel_q  <= digit_sel_d;
    end
  end

  assign number     = number_q;
  assign digit_sel  = digit_sel_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
